// File: rtl/unsigned_mul_8x8_ha_array_accumulator.sv
// ---------------------------------------------------------------------------
// unsigned_mul_8x8_ha_array_accumulator
//
// Back end of the 8x8 approximate multiplier. Takes the four half-adder
// compressed partial-product rows (carry vector b, sum vector t) from the
// ha_array stage and folds them into the final product with a single 17-bit
// adder. The adder adds one row per cycle.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   in_valid       row set on ha_array_* is valid
//   in_ready       block can accept a row set
//   ha_array_k_b   7-bit carry vector of row k (bit i weighs 2^(i+2))
//   ha_array_k_t   9-bit sum vector of row k (bit i weighs 2^i)
//   out_valid      product valid
//   out_ready      consumer accepts product
//   product        accumulated product, saturated to 16'hFFFF on overflow
//   ovf            accumulator exceeded 16 bits and product was saturated
//
// Timing: a set accepted at edge N reaches the output after the edge that adds
// row ROWS-1. The consumer samples out_valid high at edge N+ROWS+1. in_ready
// is also raised during the output handshake cycle. This lets a new set be
// accepted on the same edge and gives one product every ROWS+1 cycles.
// ---------------------------------------------------------------------------
module unsigned_mul_8x8_ha_array_accumulator #(
    parameter int unsigned ROWS      = 4,   // fixed at 4 for the 8x8 array
    parameter int unsigned ROW_SHIFT = 2,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned ACC_W     = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       ha_array_0_b,
    input  logic [6:0]       ha_array_1_b,
    input  logic [6:0]       ha_array_2_b,
    input  logic [6:0]       ha_array_3_b,
    input  logic [8:0]       ha_array_0_t,
    input  logic [8:0]       ha_array_1_t,
    input  logic [8:0]       ha_array_2_t,
    input  logic [8:0]       ha_array_3_t,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] product,
    output logic             ovf
);

    localparam int unsigned K_W = $clog2(ROWS);

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StDone
    } state_e;

    state_e           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [K_W-1:0]   k_q;
    logic [6:0]       buf_b [ROWS];
    logic [8:0]       buf_t [ROWS];

    logic [6:0]       in_b [ROWS];
    logic [8:0]       in_t [ROWS];
    logic             accept;
    logic             last_row;
    logic [9:0]       row_val;
    logic [ACC_W-1:0] row_contrib;
    logic [ACC_W-1:0] acc_sum;

    always_comb begin
        in_b[0] = ha_array_0_b;
        in_b[1] = ha_array_1_b;
        in_b[2] = ha_array_2_b;
        in_b[3] = ha_array_3_b;
        in_t[0] = ha_array_0_t;
        in_t[1] = ha_array_1_t;
        in_t[2] = ha_array_2_t;
        in_t[3] = ha_array_3_t;
    end

    // in_ready is combinational so it can follow out_ready in the handshake
    // cycle. It is held low while rst is asserted.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
        end
    end

    assign accept   = in_valid && in_ready;
    assign last_row = (k_q == K_W'(ROWS - 1));

    // R_k = t_k + (b_k << 2) is the 10-bit row value. It is weighted by 2^(ROW_SHIFT*k).
    always_comb begin
        row_val     = 10'(buf_t[k_q]) + (10'(buf_b[k_q]) << 2);
        row_contrib = ACC_W'(row_val) << (ROW_SHIFT * k_q);
        acc_sum     = acc_q + row_contrib;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            k_q       <= '0;
            out_valid <= 1'b0;
            product   <= '0;
            ovf       <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                buf_b[i] <= '0;
                buf_t[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: ;
                StAcc: begin
                    acc_q <= acc_sum;
                    k_q   <= k_q + 1'b1;
                    if (last_row) begin
                        state_q   <= StDone;
                        out_valid <= 1'b1;
                        ovf       <= acc_sum[ACC_W-1];
                        product   <= acc_sum[ACC_W-1] ? '1 : acc_sum[OUT_W-1:0];
                    end
                end
                StDone: begin
                    // Hold product/ovf until the consumer takes them.
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Accepting a set overrides the DONE->IDLE return for back-to-back use.
            if (accept) begin
                state_q <= StAcc;
                acc_q   <= '0;
                k_q     <= '0;
                for (int i = 0; i < ROWS; i++) begin
                    buf_b[i] <= in_b[i];
                    buf_t[i] <= in_t[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_accumulator.sv
module tb_unsigned_mul_8x8_ha_array_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  rb [4];
    logic [8:0]  rt [4];
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] product;
    logic        ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    unsigned_mul_8x8_ha_array_accumulator dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ha_array_0_b (rb[0]),
        .ha_array_1_b (rb[1]),
        .ha_array_2_b (rb[2]),
        .ha_array_3_b (rb[3]),
        .ha_array_0_t (rt[0]),
        .ha_array_1_t (rt[1]),
        .ha_array_2_t (rt[2]),
        .ha_array_3_t (rt[3]),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .ovf          (ovf)
    );

    // Reference: sum of (t + 4*b) * 4^k over rows, saturate above 16 bits.
    function automatic void golden(output logic [15:0] p, output logic o);
        int s = 0;
        for (int k = 0; k < 4; k++) begin
            s += (int'(rt[k]) + 4 * int'(rb[k])) * (1 << (2 * k));
        end
        o = (s > 65535);
        p = o ? 16'hFFFF : 16'(s);
    endfunction

    task automatic set_rows(input logic [6:0] b0, b1, b2, b3,
                            input logic [8:0] t0, t1, t2, t3);
        rb[0] = b0; rb[1] = b1; rb[2] = b2; rb[3] = b3;
        rt[0] = t0; rt[1] = t1; rt[2] = t2; rt[3] = t3;
    endtask

    task automatic set_random();
        for (int k = 0; k < 4; k++) begin
            rb[k] = 7'($urandom);
            rt[k] = 9'($urandom);
        end
    endtask

    // Accept the current row set, wait for the product and handshake it.
    // lat is the edge count from accept to the edge where out_valid is taken
    // (-1 on timeout).
    task automatic run_op(output logic [15:0] p, output logic o, output int lat);
        int n = 0;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) lat = -1;
        p = product;
        o = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            $display("FAIL reset_in_ready_during: got %b want 0", in_ready); n_fail++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, product, ovf, in_ready} !== {1'b0, 16'h0, 1'b0, 1'b1}) begin
            $display("FAIL reset_state: got ov=%b p=%h ovf=%b ir=%b want 0 0000 0 1",
                     out_valid, product, ovf, in_ready);
            n_fail++;
        end
    endtask

    task automatic test_zero();
        logic [15:0] p; logic o; int lat;
        set_rows(0, 0, 0, 0, 0, 0, 0, 0);
        run_op(p, o, lat);
        n_cmp++;
        if (lat !== 5) begin $display("FAIL zero_latency: got %0d want 5", lat); n_fail++; end
        n_cmp++;
        if ({p, o} !== {16'h0, 1'b0}) begin
            $display("FAIL zero_product: got %h/%b want 0000/0", p, o); n_fail++;
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            $display("FAIL zero_valid_drop: got %b want 0", out_valid); n_fail++;
        end
    endtask

    task automatic test_single_bits();
        logic [15:0] p; logic o; int lat;
        logic [15:0] exp_p [4] = '{16'd1, 16'd64, 16'd1024, 16'd4096};
        for (int i = 0; i < 4; i++) begin
            set_rows(0, 0, 0, 0, 0, 0, 0, 0);
            case (i)
                0: rt[0] = 9'h001;
                1: rt[3] = 9'h001;
                2: rb[1] = 7'h40;
                default: rt[2] = 9'h100;
            endcase
            run_op(p, o, lat);
            n_cmp++;
            if ({p, o} !== {exp_p[i], 1'b0}) begin
                $display("FAIL single_bit_%0d: got %h/%b want %h/0", i, p, o, exp_p[i]);
                n_fail++;
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] p; logic o; int lat;
        set_rows(7'h7F, 7'h7F, 7'h7F, 7'h7F, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF);
        run_op(p, o, lat);
        n_cmp++;
        if ({p, o} !== {16'hFFFF, 1'b1}) begin
            $display("FAIL ovf_saturate: got %h/%b want ffff/1", p, o); n_fail++;
        end
        set_rows(0, 0, 0, 0, 0, 0, 0, 0);
        run_op(p, o, lat);
        n_cmp++;
        if ({p, o} !== {16'h0, 1'b0}) begin
            $display("FAIL ovf_clear: got %h/%b want 0000/0", p, o); n_fail++;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] pa, pb, held; logic oa, ob; int n; int bad;
        set_random();
        golden(pa, oa);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
        n_cmp++;
        if (out_valid !== 1'b1) begin $display("FAIL bp_first_valid: got 0 want 1"); n_fail++; end
        held = product;
        set_random();            // second set offered while stalled
        golden(pb, ob);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (product !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin $display("FAIL bp_stall: got %0d bad cycles want 0", bad); n_fail++; end
        n_cmp++;
        if ({held, ovf} !== {pa, oa}) begin
            $display("FAIL bp_first_product: got %h/%b want %h/%b", held, ovf, pa, oa); n_fail++;
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin $display("FAIL bp_b2b_ready: got %b want 1", in_ready); n_fail++; end
        @(posedge clk); #1;      // output handshake and second accept
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
        n_cmp++;
        if (n !== 5) begin $display("FAIL bp_second_latency: got %0d want 5", n); n_fail++; end
        n_cmp++;
        if ({product, ovf} !== {pb, ob}) begin
            $display("FAIL bp_second_product: got %h/%b want %h/%b", product, ovf, pb, ob);
            n_fail++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        logic [15:0] exp_q [$];
        logic        exp_o [$];
        logic [15:0] gp; logic go;
        int sent = 0, got = 0, cyc = 0, last_out = -1, bad_gap = 0;
        logic hs_in, hs_out;
        logic [15:0] smp_p; logic smp_o;
        out_ready = 1'b1;
        set_random();
        if (sent == 0) rb[0] = 7'h7F;
        in_valid = 1'b1;
        while (got < 8 && cyc < 200) begin
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            smp_p  = product;
            smp_o  = ovf;
            if (hs_in) golden(gp, go);
            @(posedge clk); #1;
            cyc++;
            if (hs_out) begin
                n_cmp++;
                if (exp_q.size() == 0 || {smp_p, smp_o} !== {exp_q[0], exp_o[0]}) begin
                    $display("FAIL stream_product_%0d: got %h/%b want %h/%b", got, smp_p,
                             smp_o, (exp_q.size() != 0) ? exp_q[0] : 16'hxxxx,
                             (exp_o.size() != 0) ? exp_o[0] : 1'bx);
                    n_fail++;
                end
                if (exp_q.size() != 0) begin void'(exp_q.pop_front()); void'(exp_o.pop_front()); end
                if (last_out >= 0 && cyc - last_out != 5) bad_gap++;
                last_out = cyc;
                got++;
            end
            if (hs_in) begin
                exp_q.push_back(gp);
                exp_o.push_back(go);
                sent++;
                if (sent < 8) set_random(); else in_valid = 1'b0;
            end
        end
        n_cmp++;
        if (got !== 8) begin $display("FAIL stream_count: got %0d want 8", got); n_fail++; end
        n_cmp++;
        if (bad_gap !== 0) begin
            $display("FAIL stream_interval: got %0d irregular gaps want 0", bad_gap); n_fail++;
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] p, gp; logic o, go; int lat, seen;
        set_random();
        in_valid = 1'b1;
        @(posedge clk); #1;      // accept
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;      // now in the 3rd ACC cycle
        rst = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin $display("FAIL midrst_in_ready: got %b want 0", in_ready); n_fail++; end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, product, ovf, in_ready} !== {1'b0, 16'h0, 1'b0, 1'b1}) begin
            $display("FAIL midrst_state: got ov=%b p=%h ovf=%b ir=%b want 0 0000 0 1",
                     out_valid, product, ovf, in_ready);
            n_fail++;
        end
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin $display("FAIL midrst_no_output: got %0d valid cycles want 0", seen); n_fail++; end
        set_random();
        golden(gp, go);
        run_op(p, o, lat);
        n_cmp++;
        if ({p, o} !== {gp, go} || lat !== 5) begin
            $display("FAIL midrst_next: got %h/%b lat %0d want %h/%b lat 5", p, o, lat, gp, go);
            n_fail++;
        end
    endtask

    initial begin
        set_rows(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_zero();
        test_single_bits();
        test_overflow();
        test_backpressure();
        test_stream();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
